// File: rtl/m_vmem_wr_arbiter.sv
// Round-robin arbiter for the 256x256x16 video memory write port, with a priority clear engine.
// Build option: define ARB_STATS_EN to enable the saturating stall counter on w_stall_cnt.
`timescale 1ns/1ps
module m_vmem_wr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned BURST = 16,
  parameter int unsigned W     = 240,
  parameter int unsigned H     = 240
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [NREQ-1:0]      w_req,
  input  logic [NREQ*16-1:0]   w_adr,
  input  logic [NREQ*16-1:0]   w_dat,
  output logic [NREQ-1:0]      w_gnt,
  input  logic                 w_clr,
  input  logic [15:0]          w_clr_color,
  output logic                 w_clr_busy,
  output logic                 w_we,
  output logic [15:0]          w_wadr,
  output logic [15:0]          w_wdata,
  output logic [31:0]          w_stall_cnt
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      burst_q, burst_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic            pending_q, pending_d;
  logic [15:0]     color_q, color_d;
  logic [NREQ-1:0] gnt_d;
  logic            we_d;
  logic [15:0]     wadr_d, wdata_d;
  logic [IW-1:0]   rr_pick;
  logic            rr_any;
  logic [15:0]     own_adr, own_dat;
  logic            xfer;
  logic            clr_accept;
  logic            clr_last;

  assign xfer       = |(w_req & w_gnt);
  assign clr_accept = w_clr && !pending_q;
  assign clr_last   = (state_q == S_CLEAR) && (x_q == 8'(W-1)) && (y_q == 8'(H-1));
  assign w_clr_busy = pending_q;

  // First requesting index after the last owner, wrapping around.
  always_comb begin
    rr_pick = '0;
    rr_any  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!rr_any && w_req[j] && (((32'(last_q) + k) % NREQ) == j)) begin
          rr_any  = 1'b1;
          rr_pick = IW'(j);
        end
      end
    end
  end

  always_comb begin
    own_adr = '0;
    own_dat = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (owner_q == IW'(j)) begin
        own_adr = w_adr[16*j +: 16];
        own_dat = w_dat[16*j +: 16];
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    burst_d   = burst_q;
    x_d       = x_q;
    y_d       = y_q;
    pending_d = pending_q | clr_accept;
    color_d   = clr_accept ? w_clr_color : color_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q || w_clr) begin
          state_d = S_CLEAR;
          x_d     = '0;
          y_d     = '0;
        end else if (rr_any) begin
          state_d = S_OWN;
          owner_d = rr_pick;
          burst_d = '0;
        end
      end
      S_OWN: begin
        if (xfer) burst_d = burst_q + 8'd1;
        // A pending clear lets the in-flight transfer finish, then takes the port.
        if (!xfer || pending_q || (burst_q == 8'(BURST-1))) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      S_CLEAR: begin
        if (x_q == 8'(W-1)) begin
          x_d = '0;
          y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
        if (clr_last) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    we_d    = 1'b0;
    wadr_d  = w_wadr;
    wdata_d = w_wdata;
    if (state_d == S_OWN) begin
      for (int unsigned j = 0; j < NREQ; j++) gnt_d[j] = (owner_d == IW'(j));
    end
    if (xfer) begin
      we_d    = 1'b1;
      wadr_d  = own_adr;
      wdata_d = own_dat;
    end else if (state_q == S_CLEAR) begin
      we_d    = 1'b1;
      wadr_d  = {y_q, x_q};
      wdata_d = color_q;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      owner_q   <= '0;
      last_q    <= IW'(NREQ-1);
      burst_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
      color_q   <= '0;
      w_gnt     <= '0;
      w_we      <= 1'b0;
      w_wadr    <= '0;
      w_wdata   <= '0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
      color_q   <= color_d;
      w_gnt     <= gnt_d;
      w_we      <= we_d;
      w_wadr    <= wadr_d;
      w_wdata   <= wdata_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stall_q;

  // Cycles in which at least one requester waits without a grant.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      stall_q <= '0;
    end else if ((|(w_req & ~w_gnt)) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign w_stall_cnt = stall_q;
`else
  assign w_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_m_vmem_wr_arbiter.sv
// Self-checking bench for m_vmem_wr_arbiter: scoreboard of expected vmem writes plus directed checks.
`timescale 1ns/1ps
module tb_m_vmem_wr_arbiter;
  localparam int unsigned NREQ = 3;

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] dat;
  } wr_t;

  logic                 clk;
  logic                 w_rst;
  logic [NREQ-1:0]      w_req;
  logic [NREQ*16-1:0]   w_adr;
  logic [NREQ*16-1:0]   w_dat;
  logic [NREQ-1:0]      w_gnt;
  logic                 w_clr;
  logic [15:0]          w_clr_color;
  logic                 w_clr_busy;
  logic                 w_we;
  logic [15:0]          w_wadr;
  logic [15:0]          w_wdata;
  logic [31:0]          w_stall_cnt;

  m_vmem_wr_arbiter dut (
    .w_clk       (clk),
    .w_rst       (w_rst),
    .w_req       (w_req),
    .w_adr       (w_adr),
    .w_dat       (w_dat),
    .w_gnt       (w_gnt),
    .w_clr       (w_clr),
    .w_clr_color (w_clr_color),
    .w_clr_busy  (w_clr_busy),
    .w_we        (w_we),
    .w_wadr      (w_wadr),
    .w_wdata     (w_wdata),
    .w_stall_cnt (w_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t             exp_q[$];
  int              checks = 0;
  int              errors = 0;
  bit              mon_en = 1'b0;
  logic [NREQ-1:0] xfer_mask = '0;
  int              busy_run = 0;
  int              last_busy_run = 0;
  bit              en  [NREQ];
  int              pos [NREQ];
  int              len [NREQ];
  int              base[NREQ];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endfunction

  function automatic logic [15:0] pix(input int i, input int p);
    return 16'(((i + 1) << 12) | p);
  endfunction

  function automatic void push_req(input int i, input int b, input int from, input int to);
    for (int p = from; p <= to; p++) exp_q.push_back({16'(b + p), pix(i, p)});
  endfunction

  function automatic void push_clear(input logic [15:0] color, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({8'(k / 240), 8'(k % 240), color});
  endfunction

  // Scoreboard monitor: every vmem write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      xfer_mask = w_req & w_gnt;
      chk("gnt_onehot0", 32'($onehot0(w_gnt)), 32'd1);
      if (w_we) begin
        if (exp_q.size() == 0) begin
          chk("write_unexpected", {w_wadr, w_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("write", {w_wadr, w_wdata}, {e.adr, e.dat});
        end
      end
      if (w_clr_busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      w_req[i]          = en[i] && (pos[i] < len[i]);
      w_adr[16*i +: 16] = 16'(base[i] + pos[i]);
      w_dat[16*i +: 16] = pix(i, pos[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (xfer_mask[i]) pos[i]++;
    w_clr = 1'b0;
    drive();
  endtask

  task automatic set_req(input int i, input int b, input int n);
    en[i] = 1'b1; base[i] = b; pos[i] = 0; len[i] = n;
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++) if (en[i] && pos[i] < len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!all_done() && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(all_done()), 32'd1);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    w_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) en[i] = 1'b0;
    drive();
    tick();
    tick();
    w_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] stall_exp;
    w_rst = 1'b1; w_clr = 1'b0; w_clr_color = '0; w_req = '0; w_adr = '0; w_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1'b0; pos[i] = 0; len[i] = 0; base[i] = 0;
    end

    // Reset state, then one requester with 20 pixels: 16-burst, idle cycle, 4 more.
    do_reset();
    mon_en = 1'b1;
    set_req(0, 16'h0000, 20);
    push_req(0, 16'h0000, 0, 19);
    @(negedge clk);
    chk("rst_gnt", 32'(w_gnt), 32'd0);
    chk("rst_we", 32'(w_we), 32'd0);
    chk("rst_wadr", 32'(w_wadr), 32'd0);
    chk("rst_wdata", 32'(w_wdata), 32'd0);
    chk("rst_busy", 32'(w_clr_busy), 32'd0);
    chk("rst_stall", w_stall_cnt, 32'd0);
    for (int c = 0; c < 26; c++) begin
      if (c != 0) @(negedge clk);
      chk($sformatf("t1_gnt0_c%0d", c), 32'(w_gnt[0]), 32'((c >= 1 && c <= 16) || (c >= 18 && c <= 22)));
      chk($sformatf("t1_we_c%0d", c), 32'(w_we), 32'((c >= 2 && c <= 17) || (c >= 19 && c <= 22)));
      tick();
    end
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Three requesters contending: bursts in order 0,1,2,0,1,2.
    do_reset();
    set_req(0, 16'h1000, 32);
    set_req(1, 16'h2000, 32);
    set_req(2, 16'h3000, 32);
    push_req(0, 16'h1000, 0, 15);
    push_req(1, 16'h2000, 0, 15);
    push_req(2, 16'h3000, 0, 15);
    push_req(0, 16'h1000, 16, 31);
    push_req(1, 16'h2000, 16, 31);
    push_req(2, 16'h3000, 16, 31);
    wait_done("t2_done", 500);
    repeat (3) tick();
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear mid-burst of requester 1; a second clear during the sweep is ignored.
    set_req(1, 16'h4000, 20);
    push_req(1, 16'h4000, 0, 6);
    push_clear(16'hF800, 57600);
    push_req(1, 16'h4000, 7, 19);
    n = 0;
    while (pos[1] != 5 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_reach_pixel5", 32'(pos[1]), 32'd5);
    chk("t3_gnt1_at_pulse", 32'(w_gnt), 32'b010);
    chk("t3_busy_before", 32'(w_clr_busy), 32'd0);
    w_clr = 1'b1;
    w_clr_color = 16'hF800;
    tick();
    chk("t3_busy_rise", 32'(w_clr_busy), 32'd1);
    repeat (200) tick();
    w_clr = 1'b1;
    w_clr_color = 16'h001F;
    tick();
    n = 0;
    while (w_clr_busy && n < 60000) begin
      tick();
      n++;
    end
    chk("t3_busy_fall", 32'(w_clr_busy), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_busy_len", 32'(last_busy_run), 32'd57602);
    wait_done("t3_regrant_done", 200);
    repeat (3) tick();
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while the clear shows its 1000th write; arbitration restarts at requester 0.
    push_clear(16'h07E0, 1000);
    w_clr = 1'b1;
    w_clr_color = 16'h07E0;
    for (int k = 0; k < 1001; k++) tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    chk("t4_queue_at_reset", 32'(exp_q.size()), 32'd0);
    set_req(0, 16'h5000, 3);
    set_req(2, 16'h6000, 3);
    push_req(0, 16'h5000, 0, 2);
    push_req(2, 16'h6000, 0, 2);
    @(negedge clk);
    chk("t4_we_after_rst", 32'(w_we), 32'd0);
    chk("t4_busy_after_rst", 32'(w_clr_busy), 32'd0);
    chk("t4_gnt_after_rst", 32'(w_gnt), 32'd0);
    tick();
    chk("t4_first_gnt", 32'(w_gnt), 32'b001);
    wait_done("t4_done", 100);
    repeat (3) tick();
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Two requesters contend for 100 cycles; every one of those cycles has a waiter.
    do_reset();
    set_req(0, 16'h7000, 64);
    set_req(1, 16'h8000, 64);
    push_req(0, 16'h7000, 0, 15);
    push_req(1, 16'h8000, 0, 15);
    push_req(0, 16'h7000, 16, 31);
    push_req(1, 16'h8000, 16, 31);
    push_req(0, 16'h7000, 32, 47);
    push_req(1, 16'h8000, 32, 45);
    for (int k = 0; k < 100; k++) tick();
    for (int i = 0; i < NREQ; i++) en[i] = 1'b0;
    drive();
    repeat (4) tick();
`ifdef ARB_STATS_EN
    stall_exp = 32'd100;
`else
    stall_exp = 32'd0;
`endif
    chk("t5_stall_cnt", w_stall_cnt, stall_exp);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
